// File: rtl/screen_sequencer_pkg.sv
// Shared screen state encodings and frame-count helpers for the display pipeline.
// The SCR_* macros are the encodings also used by the game logic and debug overlay.
`ifndef SCR_MACROS_VH
`define SCR_MACROS_VH
`define SCR_STATE_W 2
`define SCR_START   2'd0
`define SCR_PLAY    2'd1
`define SCR_LOCK    2'd2
`define SCR_END     2'd3
`endif

package screen_sequencer_pkg;

  typedef enum logic [`SCR_STATE_W-1:0] {
    ST_START = `SCR_START,
    ST_PLAY  = `SCR_PLAY,
    ST_LOCK  = `SCR_LOCK,
    ST_END   = `SCR_END
  } scr_state_e;

  // A frame count of zero behaves like one: terminal count is the first tick.
  function automatic int unsigned tc_value(input int unsigned frames);
    return (frames == 0) ? 0 : frames - 1;
  endfunction

endpackage

// File: rtl/screen_sequencer_frame_timer.sv
// Saturating frame counter with synchronous clear, tick enable and terminal-count compare.
module frame_timer #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick_en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer: START -> PLAY -> LOCK -> END -> START, switching only on frame_tick.
// Optional macro SCREEN_ATTRACT_TIMEOUT_EN: idle END screen returns to START after TIMEOUT_FRAMES.
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int unsigned END_LOCK_FRAMES = 60,
  parameter int unsigned TIMEOUT_FRAMES  = 1800,
  parameter int unsigned CNT_W           = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    btn,
  input  logic                    game_over,
  output logic                    start_en,
  output logic                    game_en,
  output logic                    end_en,
  output logic                    game_rst,
  output logic [`SCR_STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] LOCK_TC    = CNT_W'(tc_value(END_LOCK_FRAMES));
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(tc_value(TIMEOUT_FRAMES));

  scr_state_e state_q, state_d;
  logic btn_q;
  logic pend_q, pend_d;
  logic start_en_q, start_en_d;
  logic game_en_q, game_en_d;
  logic end_en_q, end_en_d;
  logic game_rst_q, game_rst_d;

  logic             btn_rise;
  logic             timer_clr;
  logic             timer_tick;
  logic             timer_tc;
  logic [CNT_W-1:0] timer_tc_val;

  assign btn_rise     = btn & ~btn_q;
  // One timer serves both the LOCK hold and the END idle timeout.
  assign timer_tc_val = (state_q == ST_END) ? TIMEOUT_TC : LOCK_TC;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    game_rst_d = 1'b0;
    timer_tick = 1'b0;
    case (state_q)
      ST_START: begin
        if (frame_tick && (pend_q || btn_rise)) begin
          state_d    = ST_PLAY;
          game_rst_d = 1'b1;
        end else if (btn_rise) begin
          pend_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (frame_tick && (pend_q || game_over)) begin
          state_d = ST_LOCK;
        end else if (game_over) begin
          pend_d = 1'b1;
        end
      end
      ST_LOCK: begin
        timer_tick = frame_tick;
        if (frame_tick && timer_tc) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
`ifdef SCREEN_ATTRACT_TIMEOUT_EN
        timer_tick = frame_tick;
        if (frame_tick && (pend_q || btn_rise || timer_tc)) begin
          state_d = ST_START;
        end else if (btn_rise) begin
          pend_d = 1'b1;
        end
`else
        if (frame_tick && (pend_q || btn_rise)) begin
          state_d = ST_START;
        end else if (btn_rise) begin
          pend_d = 1'b1;
        end
`endif
      end
      default: state_d = ST_START;
    endcase
    timer_clr = (state_d != state_q);
    if (timer_clr) begin
      pend_d = 1'b0;
    end
    start_en_d = (state_d == ST_START);
    game_en_d  = (state_d == ST_PLAY);
    end_en_d   = (state_d == ST_LOCK) || (state_d == ST_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_START;
      btn_q      <= 1'b0;
      pend_q     <= 1'b0;
      start_en_q <= 1'b1;
      game_en_q  <= 1'b0;
      end_en_q   <= 1'b0;
      game_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn;
      pend_q     <= pend_d;
      start_en_q <= start_en_d;
      game_en_q  <= game_en_d;
      end_en_q   <= end_en_d;
      game_rst_q <= game_rst_d;
    end
  end

  frame_timer #(
    .CNT_W(CNT_W)
  ) u_frame_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .tick_en(timer_tick),
    .tc_val (timer_tc_val),
    .tc     (timer_tc)
  );

  assign start_en = start_en_q;
  assign game_en  = game_en_q;
  assign end_en   = end_en_q;
  assign game_rst = game_rst_q;
  assign state    = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer with END_LOCK_FRAMES=3, TIMEOUT_FRAMES=4.
module tb_screen_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn = 1'b0;
  logic       game_over = 1'b0;
  logic       start_en, game_en, end_en, game_rst;
  logic [1:0] state;

  typedef struct {
    string       name;
    int unsigned tgt;
    logic [5:0]  exp;
  } chk_t;

  chk_t        sb_q[$];
  chk_t        mon_e;
  logic [5:0]  mon_got;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned passed = 0;

  screen_sequencer #(
    .END_LOCK_FRAMES(3),
    .TIMEOUT_FRAMES (4),
    .CNT_W          (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .btn       (btn),
    .game_over (game_over),
    .start_en  (start_en),
    .game_en   (game_en),
    .end_en    (end_en),
    .game_rst  (game_rst),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares expectations queued for the current cycle on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].tgt <= cyc) begin
      mon_e   = sb_q.pop_front();
      mon_got = {state, start_en, game_en, end_en, game_rst};
      total++;
      if (mon_e.tgt != cyc) begin
        $display("FAIL %s: missed at cycle %0d (now %0d), required %b", mon_e.name, mon_e.tgt, cyc, mon_e.exp);
      end else if (mon_got !== mon_e.exp) begin
        $display("FAIL %s: got {state,start,game,end,grst}=%b required %b", mon_e.name, mon_got, mon_e.exp);
      end else begin
        passed++;
      end
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) clk1();
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    clk1();
    frame_tick = 1'b0;
  endtask

  // Expected enables follow from the state: START->start, PLAY->game, LOCK/END->end.
  task automatic expect_out(input string nm, input logic [1:0] st, input logic gr);
    chk_t e;
    e.name = nm;
    e.tgt  = cyc;
    e.exp  = {st, st == 2'd0, st == 2'd1, st[1], gr};
    sb_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clk1();
    expect_out("reset", 2'd0, 1'b0);
    clk1();
    rst = 1'b0;

    // START: btn pulse at cycle ~10, frame_tick at ~100
    idle(9);
    btn = 1'b1; clk1(); btn = 1'b0;
    idle(89);
    expect_out("start_pend_wait", 2'd0, 1'b0);
    pulse_tick();
    expect_out("start_to_play", 2'd1, 1'b1);
    clk1();
    expect_out("game_rst_one_cycle", 2'd1, 1'b0);

    // PLAY: game_over and btn together, tick later
    idle(4);
    game_over = 1'b1; btn = 1'b1; clk1(); game_over = 1'b0; btn = 1'b0;
    expect_out("play_pend", 2'd1, 1'b0);
    idle(44);
    pulse_tick();
    expect_out("play_to_lock", 2'd2, 1'b0);

    // LOCK: btn pulses discarded, END after the 3rd tick
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1; clk1(); btn = 1'b0;
      idle(5);
      pulse_tick();
      expect_out((i < 2) ? "lock_hold" : "lock_to_end", (i < 2) ? 2'd2 : 2'd3, 1'b0);
    end
    idle(5);
    pulse_tick();
    expect_out("end_no_pend", 2'd3, 1'b0);

    // END: btn held across two ticks gives one transition
    btn = 1'b1;
    idle(100);
    expect_out("end_btn_pend", 2'd3, 1'b0);
    pulse_tick();
    expect_out("end_to_start", 2'd0, 1'b0);
    idle(200);
    pulse_tick();
    expect_out("start_held_btn", 2'd0, 1'b0);
    idle(197);
    btn = 1'b0;
    idle(3);

    // Same-cycle btn edge and tick
    btn = 1'b1; frame_tick = 1'b1; clk1(); btn = 1'b0; frame_tick = 1'b0;
    expect_out("same_cycle_btn_tick", 2'd1, 1'b1);
    idle(3);
    btn = 1'b1; clk1(); btn = 1'b0;
    idle(3);
    pulse_tick();
    expect_out("play_btn_ignored", 2'd1, 1'b0);
    game_over = 1'b1; frame_tick = 1'b1; clk1(); game_over = 1'b0; frame_tick = 1'b0;
    expect_out("go_tick_same_cycle", 2'd2, 1'b0);

    // Reset mid-LOCK at counter=2
    pulse_tick();
    pulse_tick();
    expect_out("lock_cnt2", 2'd2, 1'b0);
    idle(3);
    rst = 1'b1; clk1(); rst = 1'b0;
    expect_out("mid_lock_reset", 2'd0, 1'b0);

    // Fresh game needs the full lock again
    btn = 1'b1; clk1(); btn = 1'b0;
    pulse_tick();
    expect_out("restart_play", 2'd1, 1'b1);
    game_over = 1'b1; clk1(); game_over = 1'b0;
    pulse_tick();
    expect_out("relock", 2'd2, 1'b0);
    pulse_tick();
    pulse_tick();
    expect_out("relock_full_cnt", 2'd2, 1'b0);
    pulse_tick();
    expect_out("relock_to_end", 2'd3, 1'b0);

`ifdef SCREEN_ATTRACT_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      idle(2);
      pulse_tick();
      expect_out((i < 4) ? "timeout_wait" : "timeout_to_start", (i < 4) ? 2'd3 : 2'd0, 1'b0);
    end
`else
    for (int i = 1; i <= 10; i++) begin
      idle(2);
      pulse_tick();
      expect_out("end_holds_no_timeout", 2'd3, 1'b0);
    end
`endif

    idle(3);
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      total++;
      $display("FAIL %s: never compared, required %b", mon_e.name, mon_e.exp);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
